// File: rtl/riscv_pipe_muldiv_unit.sv
// Elastic, fully pipelined RISC-V M-extension unit (MUL/MULH*/DIV*/REM*) with tag passthrough and flush.
// Defining RISCV_PIPE_MULDIV_OCC_EN adds the 'occ' occupancy-count output.
module riscv_pipe_muldiv_unit #(
  parameter int W      = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [2:0]       req_fn,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_val,
  output logic             req_rdy,
  output logic [W-1:0]     resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_val,
  input  logic             resp_rdy
`ifdef RISCV_PIPE_MULDIV_OCC_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] occ
`endif
);

  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

  // One shared 2W-bit multiplier: operand extension selects signed/unsigned halves.
  // Signed divide runs on magnitudes; the overflow case falls out naturally (|MIN| / 1 = MIN).
  function automatic logic [W-1:0] muldiv_calc(input logic [2:0] fn,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [2*W-1:0] a_x;
    logic [2*W-1:0] b_x;
    logic [2*W-1:0] prod;
    logic           neg_a;
    logic           neg_b;
    logic           b_zero;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic [W-1:0]   uq;
    logic [W-1:0]   ur;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    a_x    = {{W{((fn == FN_MULH) || (fn == FN_MULHSU)) && a[W-1]}}, a};
    b_x    = {{W{(fn == FN_MULH) && b[W-1]}}, b};
    prod   = a_x * b_x;
    b_zero = (b == {W{1'b0}});
    neg_a  = !fn[0] && a[W-1];
    neg_b  = !fn[0] && b[W-1];
    abs_a  = neg_a ? -a : a;
    abs_b  = b_zero ? {{(W-1){1'b0}}, 1'b1} : (neg_b ? -b : b);
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    q      = (neg_a ^ neg_b) ? -uq : uq;
    r      = neg_a ? -ur : ur;
    case (fn)
      FN_MUL:                       muldiv_calc = prod[W-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: muldiv_calc = prod[2*W-1:W];
      FN_DIV, FN_DIVU:              muldiv_calc = b_zero ? {W{1'b1}} : q;
      FN_REM, FN_REMU:              muldiv_calc = b_zero ? a : r;
      default:                      muldiv_calc = prod[W-1:0];
    endcase
  endfunction

  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] adv_s;
  logic [2:0]        fn0_r;
  logic [W-1:0]      a0_r;
  logic [W-1:0]      b0_r;
  logic [TAG_W-1:0]  tag0_r;
  logic [W-1:0]      calc_s;
  logic              req_go_s;

  // Advance ripple from the last stage back to stage 0; empty stages always accept.
  always_comb begin
    adv_s           = {STAGES{1'b0}};
    adv_s[STAGES-1] = !v_r[STAGES-1] || resp_rdy;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv_s[i] = !v_r[i] || adv_s[i+1];
    end
  end

  assign req_rdy  = adv_s[0] && !flush;
  assign req_go_s = req_val && req_rdy;
  assign resp_val = v_r[STAGES-1];
  assign calc_s   = muldiv_calc(fn0_r, a0_r, b0_r);

  // Stage valid bits: reset/flush clear all, otherwise shift on advance.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      v_r <= {STAGES{1'b0}};
    end else begin
      if (adv_s[0]) v_r[0] <= req_go_s;
      for (int i = 1; i < STAGES; i++) begin
        if (adv_s[i]) v_r[i] <= v_r[i-1];
      end
    end
  end

  // Stage-0 operand capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fn0_r  <= 3'd0;
      a0_r   <= {W{1'b0}};
      b0_r   <= {W{1'b0}};
      tag0_r <= {TAG_W{1'b0}};
    end else if (req_go_s) begin
      fn0_r  <= req_fn;
      a0_r   <= req_a;
      b0_r   <= req_b;
      tag0_r <= req_tag;
    end
  end

  generate
    if (STAGES == 1) begin : g_direct
      assign resp_result = calc_s;
      assign resp_tag    = tag0_r;
    end else begin : g_pipe
      logic [W-1:0]     res_r [1:STAGES-1];
      logic [TAG_W-1:0] tag_r [1:STAGES-1];

      // Result/tag stages: a stage only loads real data, so stalled outputs hold.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 1; i < STAGES; i++) begin
            res_r[i] <= {W{1'b0}};
            tag_r[i] <= {TAG_W{1'b0}};
          end
        end else begin
          if (adv_s[1] && v_r[0]) begin
            res_r[1] <= calc_s;
            tag_r[1] <= tag0_r;
          end
          for (int i = 2; i < STAGES; i++) begin
            if (adv_s[i] && v_r[i-1]) begin
              res_r[i] <= res_r[i-1];
              tag_r[i] <= tag_r[i-1];
            end
          end
        end
      end

      assign resp_result = res_r[STAGES-1];
      assign resp_tag    = tag_r[STAGES-1];
    end
  endgenerate

`ifdef RISCV_PIPE_MULDIV_OCC_EN
  localparam int OCC_W = $clog2(STAGES + 1);
  logic [OCC_W-1:0] occ_r;
  logic             resp_go_s;

  assign resp_go_s = resp_val && resp_rdy;

  // Occupancy count used by the core for drain detection.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (req_go_s && !resp_go_s) begin
      occ_r <= occ_r + OCC_W'(1'b1);
    end else if (resp_go_s && !req_go_s) begin
      occ_r <= occ_r - OCC_W'(1'b1);
    end
  end

  assign occ = occ_r;
`endif

endmodule

// File: tb/tb_riscv_pipe_muldiv_unit.sv
// Directed scoreboard bench for riscv_pipe_muldiv_unit (W=32, STAGES=4, TAG_W=5).
module tb_riscv_pipe_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [2:0]  req_fn;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;
  logic        resp_val;
  logic        resp_rdy;
`ifdef RISCV_PIPE_MULDIV_OCC_EN
  logic [2:0]  occ;
`endif

  riscv_pipe_muldiv_unit #(.W(32), .STAGES(4), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_fn(req_fn), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .req_val(req_val), .req_rdy(req_rdy),
    .resp_result(resp_result), .resp_tag(resp_tag), .resp_val(resp_val),
    .resp_rdy(resp_rdy)
`ifdef RISCV_PIPE_MULDIV_OCC_EN
    , .occ(occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  int          checks = 0;
  int          errors = 0;
  logic        s_rdy, s_val, acc, ret;
  logic [31:0] s_res;
  logic [4:0]  s_tag;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: sample at negedge, account handshakes, return #1 after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    s_rdy = req_rdy;
    s_val = resp_val;
    s_res = resp_result;
    s_tag = resp_tag;
    acc   = req_val && req_rdy && reset && !flush;
    ret   = resp_val && resp_rdy && reset && !flush;
    if (!reset || flush) begin
      sb.delete();
    end else begin
      if (ret) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_result", s_res, e.res);
          chk("resp_tag", 32'(s_tag), 32'(e.tag));
        end
      end
      if (acc) sb.push_back(pend);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] exp);
    int n;
    req_fn = fn; req_a = a; req_b = b; req_tag = tag; req_val = 1'b1;
    pend = '{res: exp, tag: tag};
    n = 0;
    step();
    while (!acc && n < 50) begin
      step();
      n++;
    end
    chk("send_accept", 32'(acc), 32'd1);
    req_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic drive_bp(input int k);
    if (k <= 6) begin
      req_fn = 3'd0; req_a = 32'(k); req_b = 32'd3; req_tag = 5'(k);
      pend = '{res: 32'(k * 3), tag: 5'(k)};
      req_val = 1'b1;
    end else begin
      req_val = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int idx;
    int n_acc;
    reset = 1'b0; flush = 1'b0; req_fn = 3'd0; req_a = 32'd0; req_b = 32'd0;
    req_tag = 5'd0; req_val = 1'b0; resp_rdy = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_tag", 32'(resp_tag), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
`ifdef RISCV_PIPE_MULDIV_OCC_EN
    chk("rst_occ", 32'(occ), 32'd0);
`endif
    reset = 1'b1;

    // Latency: accept edge counts as the first of STAGES edges.
    resp_rdy = 1'b1;
    req_fn = 3'd0; req_a = 32'd7; req_b = 32'hFFFFFFFD; req_tag = 5'd9; req_val = 1'b1;
    pend = '{res: 32'hFFFFFFEB, tag: 5'd9};
    step();
    chk("lat_accept", 32'(acc), 32'd1);
    req_val = 1'b0;
    lat = 1;
    while (!resp_val && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    drain();

    // Arithmetic, back-to-back with results checked by the scoreboard.
    send(3'd1, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000);
    send(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
    send(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3, 32'hFFFFFFFF);
    send(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd4, 32'hFFFFFFFD);
    send(3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd5, 32'hFFFFFFFF);
    send(3'd4, 32'd5, 32'd0, 5'd6, 32'hFFFFFFFF);
    send(3'd7, 32'd5, 32'd0, 5'd7, 32'd5);
    send(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000);
    send(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'd0);
    send(3'd5, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'h7FFFFFFC);
    send(3'd7, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'd1);
    send(3'd6, 32'h80000000, 32'd0, 5'd12, 32'h80000000);
    drain();

    // Backpressure: 6 ops offered while the consumer stalls for 8 cycles.
    resp_rdy = 1'b0;
    idx = 1;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive_bp(idx);
      step();
      if (acc) begin
        idx++;
        n_acc++;
      end
      if (s_val) chk("stall_stable", s_res, 32'd3);
    end
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_full_rdy", 32'(s_rdy), 32'd0);
    chk("bp_head_tag", 32'(s_tag), 32'd1);
`ifdef RISCV_PIPE_MULDIV_OCC_EN
    chk("bp_occ", 32'(occ), 32'd4);
`endif
    resp_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_bp(idx);
      step();
      if (k == 0) chk("bp_ripple_rdy", 32'(s_rdy), 32'd1);
      chk("bp_stream_val", 32'(s_val), 32'd1);
      if (acc) idx++;
    end
    req_val = 1'b0;
    chk("bp_all_out", 32'(sb.size()), 32'd0);

    // Bubble collapse: A, two idle cycles, B, consumer stalled.
    resp_rdy = 1'b0;
    send(3'd0, 32'd2, 32'd3, 5'd10, 32'd6);
    step();
    step();
    send(3'd0, 32'd4, 32'd5, 5'd11, 32'd20);
    for (int c = 0; c < 5; c++) step();
    chk("bub_rdy", 32'(s_rdy), 32'd1);
    chk("bub_head", 32'(s_tag), 32'd10);
    resp_rdy = 1'b1;
    step();
    chk("bub_a_val", 32'(s_val), 32'd1);
    chk("bub_a_tag", 32'(s_tag), 32'd10);
    step();
    chk("bub_b_val", 32'(s_val), 32'd1);
    chk("bub_b_tag", 32'(s_tag), 32'd11);
    chk("bub_empty", 32'(sb.size()), 32'd0);

    // Flush with 3 ops in flight and a request offered in the same cycle.
    resp_rdy = 1'b0;
    send(3'd0, 32'd1, 32'd1, 5'd20, 32'd1);
    send(3'd0, 32'd2, 32'd1, 5'd21, 32'd2);
    send(3'd0, 32'd3, 32'd1, 5'd22, 32'd3);
    req_fn = 3'd0; req_a = 32'd9; req_b = 32'd9; req_tag = 5'd23; req_val = 1'b1;
    flush = 1'b1;
    step();
    chk("flush_rdy", 32'(s_rdy), 32'd0);
    flush = 1'b0;
    req_val = 1'b0;
    chk("flush_val", 32'(resp_val), 32'd0);
`ifdef RISCV_PIPE_MULDIV_OCC_EN
    chk("flush_occ", 32'(occ), 32'd0);
`endif
    step();
    chk("flush_val2", 32'(resp_val), 32'd0);
    resp_rdy = 1'b1;
    send(3'd0, 32'h1234, 32'h10, 5'd24, 32'h12340);
    drain();

    // Same scenario using reset instead of flush.
    resp_rdy = 1'b0;
    send(3'd0, 32'd5, 32'd1, 5'd25, 32'd5);
    send(3'd0, 32'd6, 32'd1, 5'd26, 32'd6);
    send(3'd0, 32'd7, 32'd1, 5'd27, 32'd7);
    req_fn = 3'd0; req_a = 32'd9; req_b = 32'd9; req_tag = 5'd28; req_val = 1'b1;
    reset = 1'b0;
    step();
    req_val = 1'b0;
    chk("rst2_val", 32'(resp_val), 32'd0);
    chk("rst2_result", resp_result, 32'd0);
    chk("rst2_tag", 32'(resp_tag), 32'd0);
    chk("rst2_rdy", 32'(req_rdy), 32'd1);
`ifdef RISCV_PIPE_MULDIV_OCC_EN
    chk("rst2_occ", 32'(occ), 32'd0);
`endif
    reset = 1'b1;
    step();
    chk("rst2_val2", 32'(resp_val), 32'd0);
    resp_rdy = 1'b1;
    send(3'd0, 32'd11, 32'd3, 5'd29, 32'd33);
    drain();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
